cpu: RTL and testbench

- 5-stage pipelined MIPS-subset CPU: IF, ID, EX, MEM, WB.
- Contains its own instruction ROM and data RAM; top-level block of the design.
- A BRK instruction halts the pipeline; a pulse on continue_sig resumes execution.
- Debug outputs expose retirement and halt state for verification.

---
 rtl/cpu.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_cpu.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// cpu: 5-stage (IF/ID/EX/MEM/WB) MIPS-subset core with its own ROM and RAM.
// In : clk, rst_n (synchronous, active-high), continue_sig (resume from BRK).
// Out: pc_out (IF pc), halted, wb_en/wb_addr/wb_data (retiring write).
// Macro CPU_FORWARDING_EN: forwarding + 1-cycle load-use stall;
// undefined: no forwarding, ID interlocks on any RAW against EX/MEM/WB.
module cpu #(
  parameter string IMEM_FILE  = "imem.hex",
  parameter int    IMEM_DEPTH = 256,
  parameter int    DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        continue_sig,
  output logic [31:0] pc_out,
  output logic        halted,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  typedef enum logic [2:0] {
    A_ADD, A_SUB, A_AND, A_OR, A_SLT
  } alu_op_t;

  typedef enum logic {S_RUN, S_HALT} hstate_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [25:0] jidx;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    alu_op_t     op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] sdata;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  dest;
    logic        reg_write;
  } mem_wb_t;

  logic        rst;
  logic [31:0] pc, pc4;
  if_id_t      if_id;
  id_ex_t      id_ex, dec;
  ex_mem_t     ex_mem, ex_next;
  mem_wb_t     mem_wb, wb_next;
  hstate_t     hs_q, hs_d;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] rf   [32];

  assign rst = rst_n;

  // ---------------- IF ----------------
  assign pc4    = pc + 32'd4;
  assign pc_out = pc;

  // ---------------- ID ----------------
  logic [5:0]  id_opc, id_fn;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        is_r, is_addi, is_lw, is_sw;
  logic        is_beq, is_j, is_brk;
  logic        use_rs, use_rt, id_brk;
  logic [31:0] rd_rs, rd_rt;

  assign id_opc  = if_id.instr[31:26];
  assign id_rs   = if_id.instr[25:21];
  assign id_rt   = if_id.instr[20:16];
  assign id_rd   = if_id.instr[15:11];
  assign id_fn   = if_id.instr[5:0];
  assign is_r    = id_opc == 6'h00;
  assign is_addi = id_opc == 6'h08;
  assign is_lw   = id_opc == 6'h23;
  assign is_sw   = id_opc == 6'h2B;
  assign is_beq  = id_opc == 6'h04;
  assign is_j    = id_opc == 6'h02;
  assign is_brk  = id_opc == 6'h3F;

  // WB write-through so a same-cycle read sees the new value
  always_comb begin
    rd_rs = rf[id_rs];
    rd_rt = rf[id_rt];
    if (mem_wb.reg_write && mem_wb.dest == id_rs) rd_rs = mem_wb.data;
    if (mem_wb.reg_write && mem_wb.dest == id_rt) rd_rt = mem_wb.data;
    if (id_rs == 5'd0) rd_rs = '0;
    if (id_rt == 5'd0) rd_rt = '0;
  end

  always_comb begin
    dec      = '0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    id_brk   = 1'b0;
    dec.pc4  = if_id.pc4;
    dec.a    = rd_rs;
    dec.b    = rd_rt;
    dec.imm  = {{16{if_id.instr[15]}}, if_id.instr[15:0]};
    dec.jidx = if_id.instr[25:0];
    dec.rs   = id_rs;
    dec.rt   = id_rt;
    unique case (1'b1)
      is_r: begin
        use_rs        = 1'b1;
        use_rt        = 1'b1;
        dec.dest      = id_rd;
        dec.reg_write = 1'b1;
        case (id_fn)
          6'h20: dec.op = A_ADD;
          6'h22: dec.op = A_SUB;
          6'h24: dec.op = A_AND;
          6'h25: dec.op = A_OR;
          6'h2A: dec.op = A_SLT;
          default: begin
            use_rs        = 1'b0;
            use_rt        = 1'b0;
            dec.dest      = '0;
            dec.reg_write = 1'b0;
          end
        endcase
      end
      is_addi: begin
        use_rs        = 1'b1;
        dec.dest      = id_rt;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      is_lw: begin
        use_rs        = 1'b1;
        dec.dest      = id_rt;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.alu_src   = 1'b1;
      end
      is_sw: begin
        use_rs        = 1'b1;
        use_rt        = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      is_beq: begin
        use_rs     = 1'b1;
        use_rt     = 1'b1;
        dec.branch = 1'b1;
      end
      is_j:   dec.jump = 1'b1;
      is_brk: id_brk   = 1'b1;
      default: ;
    endcase
    // r0 writes never retire, and never count as hazards
    if (dec.dest == 5'd0) dec.reg_write = 1'b0;
  end

  // ---------------- hazards ----------------
  logic hz_ex, data_stall;

  assign hz_ex = id_ex.reg_write &&
    ((use_rs && id_rs == id_ex.dest) ||
     (use_rt && id_rt == id_ex.dest));

`ifdef CPU_FORWARDING_EN
  assign data_stall = hz_ex && id_ex.mem_read;
`else
  logic hz_mem, hz_wb;
  logic unused_fwd;

  assign hz_mem = ex_mem.reg_write &&
    ((use_rs && id_rs == ex_mem.dest) ||
     (use_rt && id_rt == ex_mem.dest));
  assign hz_wb = mem_wb.reg_write &&
    ((use_rs && id_rs == mem_wb.dest) ||
     (use_rt && id_rt == mem_wb.dest));
  assign data_stall = hz_ex || hz_mem || hz_wb;
  assign unused_fwd = ^{id_ex.rs, id_ex.rt};
`endif

  // ---------------- EX ----------------
  logic [31:0] mem_val, dmem_rd;
  logic [31:0] fa, fb, alu_b, alu_y, ex_tgt;
  logic        ex_take;

  assign dmem_rd = dmem[ex_mem.res[DAW+1:2]];
  assign mem_val = ex_mem.mem_read ? dmem_rd : ex_mem.res;

`ifdef CPU_FORWARDING_EN
  // MEM-stage result wins over the older WB-stage one
  always_comb begin
    fa = id_ex.a;
    fb = id_ex.b;
    if (ex_mem.reg_write && ex_mem.dest == id_ex.rs)
      fa = mem_val;
    else if (mem_wb.reg_write && mem_wb.dest == id_ex.rs)
      fa = mem_wb.data;
    if (ex_mem.reg_write && ex_mem.dest == id_ex.rt)
      fb = mem_val;
    else if (mem_wb.reg_write && mem_wb.dest == id_ex.rt)
      fb = mem_wb.data;
  end
`else
  assign fa = id_ex.a;
  assign fb = id_ex.b;
`endif

  assign alu_b = id_ex.alu_src ? id_ex.imm : fb;

  always_comb begin
    alu_y = '0;
    unique case (id_ex.op)
      A_ADD:   alu_y = fa + alu_b;
      A_SUB:   alu_y = fa - alu_b;
      A_AND:   alu_y = fa & alu_b;
      A_OR:    alu_y = fa | alu_b;
      A_SLT:   alu_y = {31'b0, $signed(fa) < $signed(alu_b)};
      default: alu_y = '0;
    endcase
  end

  assign ex_take = (id_ex.branch && fa == fb) || id_ex.jump;
  assign ex_tgt  = id_ex.jump
    ? {id_ex.pc4[31:28], id_ex.jidx, 2'b00}
    : id_ex.pc4 + {id_ex.imm[29:0], 2'b00};

  always_comb begin
    ex_next           = '0;
    ex_next.res       = alu_y;
    ex_next.sdata     = fb;
    ex_next.dest      = id_ex.dest;
    ex_next.reg_write = id_ex.reg_write;
    ex_next.mem_read  = id_ex.mem_read;
    ex_next.mem_write = id_ex.mem_write;
  end

  // ---------------- MEM ----------------
  always_comb begin
    wb_next           = '0;
    wb_next.reg_write = ex_mem.reg_write;
    wb_next.dest      = ex_mem.dest;
    if (ex_mem.reg_write) wb_next.data = mem_val;
  end

  always_ff @(posedge clk) begin
    if (!rst && ex_mem.mem_write)
      dmem[ex_mem.res[DAW+1:2]] <= ex_mem.sdata;
  end

  // ---------------- halt control ----------------
  logic resume, hold;

  assign halted = hs_q == S_HALT;
  assign resume = halted && continue_sig;
  // BRK parks in ID until resumed; a taken older branch kills it
  assign hold   = !ex_take && (data_stall || (id_brk && !resume));

  always_comb begin
    hs_d = hs_q;
    unique case (hs_q)
      S_RUN:   if (id_brk && !ex_take) hs_d = S_HALT;
      S_HALT:  if (continue_sig) hs_d = S_RUN;
      default: hs_d = S_RUN;
    endcase
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      if_id  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
      hs_q   <= S_RUN;
    end else begin
      hs_q <= hs_d;
      if (ex_take) begin
        pc    <= ex_tgt;
        if_id <= '0;
        id_ex <= '0;
      end else if (hold) begin
        id_ex <= '0;
      end else begin
        pc          <= pc4;
        if_id.pc4   <= pc4;
        if_id.instr <= imem[pc[IAW+1:2]];
        id_ex       <= dec;
      end
      ex_mem <= ex_next;
      mem_wb <= wb_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (mem_wb.reg_write) begin
      rf[mem_wb.dest] <= mem_wb.data;
    end
  end

  // ---------------- WB ----------------
  assign wb_en   = mem_wb.reg_write;
  assign wb_addr = mem_wb.dest;
  assign wb_data = mem_wb.data;
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed programs for the cpu pipeline.
// Checks retirement order/values, branches, BRK halt/resume and reset.
module tb_cpu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        continue_sig = 1'b0;
  logic [31:0] pc_out;
  logic        halted;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_tot = 0;
  int n_bad = 0;
  int cyc = 0;
  int dev = 0;

  logic [31:0] prog [$];
  logic [31:0] la [$];
  logic [31:0] ld [$];
  logic [31:0] lc [$];
  logic [31:0] ea [$];
  logic [31:0] ed [$];

  cpu #(.IMEM_FILE("")) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .continue_sig (continue_sig),
    .pc_out       (pc_out),
    .halted       (halted),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data)
  );

  always #5 clk = ~clk;

  // cyc+1 is the cycle number counted from reset release (first = 1)
  always @(posedge clk) cyc <= rst_n ? 0 : cyc + 1;

  always @(negedge clk) begin
    if (!rst_n && wb_en) begin
      la.push_back(32'(wb_addr));
      ld.push_back(wb_data);
      lc.push_back(32'(cyc + 1));
    end
  end

  function automatic logic [31:0] rt_op(
    input int rd, input int rs, input int rt, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] it_op(
    input logic [5:0] opc, input int rt, input int rs, input int imm);
    return {opc, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_op(input int idx);
    return {6'h02, 26'(idx)};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ex(input int a, input logic [31:0] d);
    ea.push_back(32'(a));
    ed.push_back(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    continue_sig = 1'b0;
    for (int i = 0; i < 256; i++)
      dut.imem[i] = (i < prog.size()) ? prog[i] : 32'h0;
    @(negedge clk);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    la.delete(); ld.delete(); lc.delete();
    ea.delete(); ed.delete();
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (la.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int k = 0;
    while (halted !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(halted), 32'd1);
  endtask

  task automatic check_log(input string tag);
    for (int i = 0; i < ea.size(); i++) begin
      if (i < la.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), la[i], ea[i]);
        chk($sformatf("%s_data%0d", tag, i), ld[i], ed[i]);
      end
    end
    chk({tag, "_count"}, 32'(la.size()), 32'(ea.size()));
  endtask

  task automatic load_prog_a();
    prog.delete();
    prog.push_back(it_op(6'h08, 1, 0, 5));
    prog.push_back(it_op(6'h08, 2, 0, 7));
    prog.push_back(rt_op(3, 1, 2, 6'h20));
    prog.push_back(it_op(6'h2B, 3, 0, 0));
    prog.push_back(it_op(6'h23, 4, 0, 0));
    prog.push_back(rt_op(5, 4, 4, 6'h20));
    prog.push_back(rt_op(10, 1, 2, 6'h22));
    prog.push_back(rt_op(11, 10, 1, 6'h2A));
    prog.push_back(rt_op(12, 1, 10, 6'h2A));
    prog.push_back(rt_op(13, 1, 2, 6'h24));
    prog.push_back(rt_op(14, 1, 10, 6'h25));
    prog.push_back(it_op(6'h08, 15, 0, -1));
    prog.push_back(it_op(6'h08, 16, 15, 1));
    prog.push_back(rt_op(17, 15, 15, 6'h20));
    prog.push_back(it_op(6'h08, 0, 1, 9));
    prog.push_back(it_op(6'h2B, 1, 0, 1024));
    prog.push_back(it_op(6'h23, 18, 0, 0));
    prog.push_back(j_op(17));
  endtask

  task automatic load_prog_c();
    prog.delete();
    prog.push_back(it_op(6'h08, 1, 0, 2));
    prog.push_back(32'hFC00_0000);
    prog.push_back(it_op(6'h08, 9, 0, 4));
    prog.push_back(32'hFC00_0000);
    prog.push_back(it_op(6'h08, 23, 0, 5));
    prog.push_back(j_op(5));
  endtask

  initial begin
    // ---- program A: ALU ops, load/store, wrap cases ----
    load_prog_a();
    do_reset();
    ex(1, 32'd5);  ex(2, 32'd7);  ex(3, 32'd12);
    ex(4, 32'd12); ex(5, 32'd24);
    ex(10, 32'hFFFF_FFFE); ex(11, 32'd1); ex(12, 32'd0);
    ex(13, 32'd5); ex(14, 32'hFFFF_FFFF);
    ex(15, 32'hFFFF_FFFF); ex(16, 32'd0);
    ex(17, 32'hFFFF_FFFE); ex(18, 32'd5);
    wait_log(14, 400);
    repeat (30) @(negedge clk);
    check_log("A");
`ifdef CPU_FORWARDING_EN
    chk("A_t_r1", lc[0], 32'd5);
    chk("A_t_r2", lc[1], 32'd6);
    chk("A_t_r3", lc[2], 32'd7);
    chk("A_lw_bubble", lc[4] - lc[3], 32'd2);
`else
    chk("A_t_r1", lc[0], 32'd5);
    chk("A_t_r3", lc[2], 32'd10);
`endif

    // ---- reset mid-stream, then restart from 0 ----
    do_reset();
    repeat (7) @(negedge clk);
    do_reset();
    ex(1, 32'd5);
    wait_log(1, 40);
    chk("R_first_addr", la[0], 32'd1);
    chk("R_first_data", ld[0], 32'd5);
    chk("R_first_cyc", lc[0], 32'd5);

    // ---- program B: taken/not-taken beq, j ----
    prog.delete();
    prog.push_back(it_op(6'h08, 1, 0, 1));
    prog.push_back(it_op(6'h04, 1, 1, 2));
    prog.push_back(it_op(6'h08, 6, 0, 99));
    prog.push_back(it_op(6'h08, 7, 0, 99));
    prog.push_back(it_op(6'h08, 8, 0, 3));
    prog.push_back(it_op(6'h04, 0, 1, 1));
    prog.push_back(it_op(6'h08, 20, 0, 6));
    prog.push_back(j_op(9));
    prog.push_back(it_op(6'h08, 21, 0, 77));
    prog.push_back(it_op(6'h08, 22, 0, 8));
    prog.push_back(j_op(10));
    do_reset();
    ex(1, 32'd1); ex(8, 32'd3); ex(20, 32'd6); ex(22, 32'd8);
    wait_log(4, 300);
    repeat (30) @(negedge clk);
    check_log("B");

    // ---- program C: BRK halt and resume ----
    load_prog_c();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    // BRK sits in ID, not yet halted: this pulse must be ignored
    continue_sig = 1'b1;
    @(negedge clk);
    continue_sig = 1'b0;
    chk("C_early_cont", 32'(halted), 32'd1);
    chk("C_halt_pc", pc_out, 32'd8);
    dev = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (halted !== 1'b1 || pc_out !== 32'd8) dev++;
    end
    chk("C_hold", 32'(dev), 32'd0);
    ex(1, 32'd2);
    check_log("C1");
    continue_sig = 1'b1;
    @(negedge clk);
    continue_sig = 1'b0;
    chk("C_resumed", 32'(halted), 32'd0);
    wait_halt("C_brk2_halt", 20);
    chk("C_brk2_pc", pc_out, 32'd16);
    repeat (20) @(negedge clk);
    ex(9, 32'd4);
    check_log("C2");
    continue_sig = 1'b1;
    @(negedge clk);
    continue_sig = 1'b0;
    wait_log(3, 40);
    ex(23, 32'd5);
    check_log("C3");
    chk("C_end_run", 32'(halted), 32'd0);

    // ---- reset while halted ----
    do_reset();
    wait_halt("H_halt", 20);
    do_reset();
    ex(1, 32'd2);
    wait_log(1, 20);
    check_log("H");
    wait_halt("H_rehalt", 20);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
